// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serialises instruction-fetch and data load/store
// requests onto one shared bus, one access in flight at a time. Data has
// priority over fetch. A watchdog forces completion of a stalled access and
// flags it through the sticky mem_err output.
module mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hBAD0_BAD0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] IREQ  = 3'd1;
  localparam logic [2:0] DREQ  = 3'd2;
  localparam logic [2:0] IRESP = 3'd3;
  localparam logic [2:0] DRESP = 3'd4;

  // Last watchdog count before the access is forced to complete.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  wd_reg, wd_next;
  logic        in_req;
  logic        expired;
  logic        finish;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_sel_reg;
  logic [31:0] i_rdata_reg;
  logic [31:0] d_rdata_reg;
  logic        mem_err_reg;

  assign in_req  = (state_reg == IREQ) || (state_reg == DREQ);
  // An ack arriving on the limit cycle wins over the timeout.
  assign expired = in_req && !mem_ack && (wd_reg == WD_LIMIT);
  assign finish  = in_req && (mem_ack || expired);

  // Next-state and watchdog logic; requests are only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    wd_next    = wd_reg;
    case (state_reg)
      IDLE: begin
        wd_next = 8'd0;
        if (d_wen || d_ren)
          state_next = DREQ;
        else if (i_ren)
          state_next = IREQ;
      end
      IREQ: begin
        if (mem_ack || expired)
          state_next = IRESP;
        else
          wd_next = wd_reg + 8'd1;
      end
      DREQ: begin
        if (mem_ack || expired)
          state_next = DRESP;
        else
          wd_next = wd_reg + 8'd1;
      end
      IRESP, DRESP: begin
        wd_next    = 8'd0;
        state_next = IDLE;
      end
      default: begin
        wd_next    = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // State and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wd_reg    <= 8'd0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
    end
  end

  // Latch the winning request into the bus registers when leaving IDLE so
  // the bus sees stable values for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      mem_sel_reg   <= 4'd0;
    end else if (state_reg == IDLE) begin
      if (d_wen || d_ren) begin
        mem_we_reg    <= d_wen;
        mem_addr_reg  <= d_addr;
        mem_wdata_reg <= d_wdata;
        mem_sel_reg   <= d_sel;
      end else if (i_ren) begin
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= i_addr;
        mem_wdata_reg <= 32'd0;
        mem_sel_reg   <= 4'hF;
      end
    end
  end

  // Capture read data (or the error word) as the access completes; stores
  // leave d_rdata untouched. The timeout flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_reg <= 32'd0;
      d_rdata_reg <= 32'd0;
      mem_err_reg <= 1'b0;
    end else if (finish) begin
      if (state_reg == IREQ)
        i_rdata_reg <= mem_ack ? mem_rdata : ERR_WORD;
      else if (!mem_we_reg)
        d_rdata_reg <= mem_ack ? mem_rdata : ERR_WORD;
      if (expired)
        mem_err_reg <= 1'b1;
    end
  end

  assign mem_req   = in_req;
  assign i_ready   = (state_reg == IRESP);
  assign d_ready   = (state_reg == DRESP);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_sel   = mem_sel_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: scenario tasks drive requests and check bus
// behaviour inline; a scoreboard of expected read data is popped on every
// ready pulse.
module tb_mem_arbiter;
  localparam int          TO   = 4;
  localparam logic [31:0] ERRW = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ren, d_ren, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic        i_ready, d_ready;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        auto_ack   = 1'b0;
  logic        manual_ack = 1'b0;
  logic [31:0] bus_data   = 32'd0;
  int          ack_delay  = 2;   // ack in mem_req cycle ack_delay+1; -1 = never
  int          req_cycles = 0;
  int          episodes   = 0;
  int          last_len   = 0;
  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          order_q[$];       // 1 = fetch completion, 2 = data completion
  logic [31:0] d_model = 32'd0;

  always #5 clk = ~clk;

  assign mem_ack   = auto_ack | manual_ack;
  assign mem_rdata = bus_data;

  mem_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_err(mem_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Bus responder: counts mem_req episodes and their length, acks on cue.
  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      if (req_cycles == 1) episodes++;
    end else begin
      if (req_cycles != 0) last_len = req_cycles;
      req_cycles = 0;
    end
    auto_ack = mem_req && (ack_delay >= 0) && (req_cycles == ack_delay + 1);
  end

  // Scoreboard: every ready pulse consumes one expected read-data value.
  always @(negedge clk) begin
    if (i_ready === 1'b1) begin
      logic [31:0] e;
      order_q.push_back(1);
      vectors++;
      if (i_exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL i_unexpected: i_ready pulsed, i_rdata=%h, no fetch pending", i_rdata);
      end else begin
        e = i_exp_q.pop_front();
        if (i_rdata !== e) begin
          miscompares++;
          $display("FAIL i_rdata: got %h expected %h", i_rdata, e);
        end else $display("fetch complete: i_rdata=%h", i_rdata);
      end
    end
    if (d_ready === 1'b1) begin
      logic [31:0] e;
      order_q.push_back(2);
      vectors++;
      if (d_exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL d_unexpected: d_ready pulsed, d_rdata=%h, no data access pending", d_rdata);
      end else begin
        e = d_exp_q.pop_front();
        if (d_rdata !== e) begin
          miscompares++;
          $display("FAIL d_rdata: got %h expected %h", d_rdata, e);
        end else $display("data complete: d_rdata=%h", d_rdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_i(output int n);
    n = 0;
    while (i_ready !== 1'b1 && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_d(output int n);
    n = 0;
    while (d_ready !== 1'b1 && n < 50) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_ren = 0; d_ren = 0; d_wen = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
    tick(); tick();
    vectors++;
    if ({mem_req, i_ready, d_ready, mem_err, mem_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got req/ir/dr/err/we=%b expected 00000",
               {mem_req, i_ready, d_ready, mem_err, mem_we});
    end
    vectors++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata, mem_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: i=%h d=%h a=%h w=%h s=%h expected all 0",
               i_rdata, d_rdata, mem_addr, mem_wdata, mem_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    int n;
    ack_delay = 2; bus_data = 32'h0051_0113;
    i_ren = 1; i_addr = 32'h0000_0040;
    i_exp_q.push_back(32'h0051_0113);
    tick();
    vectors++;
    if ({mem_req, mem_we, mem_sel, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin
      miscompares++;
      $display("FAIL fetch_bus: req=%b we=%b sel=%h addr=%h expected 1 0 f 00000040",
               mem_req, mem_we, mem_sel, mem_addr);
    end
    wait_i(n);
    vectors++;
    if (i_ready !== 1'b1 || n != 3) begin
      miscompares++;
      $display("FAIL fetch_latency: ready=%b after %0d cycles expected 1 after 3", i_ready, n);
    end
    i_ren = 0;
    tick();
    vectors++;
    if (i_ready !== 1'b0 || i_rdata !== 32'h0051_0113) begin
      miscompares++;
      $display("FAIL fetch_hold: ready=%b rdata=%h expected 0 00510113", i_ready, i_rdata);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    int n, e0;
    ack_delay = 1; bus_data = 32'h1111_0000;
    e0 = episodes; order_q.delete();
    i_ren = 1; i_addr = 32'h44; d_ren = 1; d_addr = 32'h200; d_sel = 4'hC;
    d_exp_q.push_back(32'h1111_0000); d_model = 32'h1111_0000;
    i_exp_q.push_back(32'h2222_0000);
    tick();
    vectors++;
    if ({mem_addr, mem_we, mem_sel} !== {32'h200, 1'b0, 4'hC}) begin
      miscompares++;
      $display("FAIL prio_first: addr=%h we=%b sel=%h expected 00000200 0 c", mem_addr, mem_we, mem_sel);
    end
    wait_d(n);
    d_ren = 0; bus_data = 32'h2222_0000;
    tick();
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_idle: mem_req=%b expected 0", mem_req);
    end
    tick();
    vectors++;
    if ({mem_req, mem_addr, mem_sel} !== {1'b1, 32'h44, 4'hF}) begin
      miscompares++;
      $display("FAIL prio_second: req=%b addr=%h sel=%h expected 1 00000044 f", mem_req, mem_addr, mem_sel);
    end
    wait_i(n);
    i_ren = 0;
    tick(); tick();
    vectors++;
    if (episodes - e0 != 2 || order_q.size() != 2 || order_q[0] != 2 || order_q[1] != 1) begin
      miscompares++;
      $display("FAIL prio_order: %0d episodes, %0d completions expected 2 episodes data-then-fetch",
               episodes - e0, order_q.size());
    end
  endtask

  task automatic test_store();
    int n;
    ack_delay = 1; bus_data = 32'h5555_5555;
    d_wen = 1; d_addr = 32'h0000_1004; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
    d_exp_q.push_back(d_model);
    tick();
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_sel} !==
        {1'b1, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0011}) begin
      miscompares++;
      $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h sel=%h expected 1 1 00001004 deadbeef 3",
               mem_req, mem_we, mem_addr, mem_wdata, mem_sel);
    end
    wait_d(n);
    vectors++;
    if (d_ready !== 1'b1 || n != 2) begin
      miscompares++;
      $display("FAIL store_latency: ready=%b after %0d cycles expected 1 after 2", d_ready, n);
    end
    d_wen = 0;
    tick(); tick();
  endtask

  task automatic test_ack_at_limit();
    int n;
    ack_delay = TO - 1; bus_data = 32'h1234_5678;
    d_ren = 1; d_addr = 32'h300; d_sel = 4'hF;
    d_exp_q.push_back(32'h1234_5678); d_model = 32'h1234_5678;
    tick();
    wait_d(n);
    vectors++;
    if (d_ready !== 1'b1 || n != TO || mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_limit: ready=%b after %0d err=%b expected 1 after %0d err 0", d_ready, n, mem_err, TO);
    end
    d_ren = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    ack_delay = -1;
    d_ren = 1; d_addr = 32'h400;
    d_exp_q.push_back(ERRW); d_model = ERRW;
    tick();
    wait_d(n);
    vectors++;
    if (d_ready !== 1'b1 || last_len != TO || mem_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: ready=%b req_len=%0d err=%b expected 1 %0d 1", d_ready, last_len, mem_err, TO);
    end
    d_ren = 0;
    tick(); tick();
  endtask

  task automatic test_held_request();
    int n, e0;
    ack_delay = 1; bus_data = 32'hCAFE_0001;
    e0 = episodes;
    d_ren = 1; d_addr = 32'h500;
    d_exp_q.push_back(32'hCAFE_0001); d_exp_q.push_back(32'hCAFE_0001);
    d_model = 32'hCAFE_0001;
    tick();
    wait_d(n);
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL held_resp: mem_req=%b during ready expected 0", mem_req);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b0 || d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL held_idle: req=%b ready=%b expected 0 0", mem_req, d_ready);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
      miscompares++;
      $display("FAIL held_second: req=%b addr=%h expected 1 00000500", mem_req, mem_addr);
    end
    wait_d(n);
    d_ren = 0;
    tick(); tick();
    vectors++;
    if (episodes - e0 != 2 || mem_err !== 1'b1) begin
      miscompares++;
      $display("FAIL held_count: %0d episodes err=%b expected 2 episodes err 1", episodes - e0, mem_err);
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = -1;
    d_ren = 1; d_addr = 32'h600;
    d_exp_q.push_back(ERRW);
    tick(); tick();
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: mem_req=%b expected 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    d_exp_q.delete(); d_model = 32'd0; d_ren = 0;
    vectors++;
    if ({mem_req, d_ready, mem_err} !== 3'b0 || {d_rdata, i_rdata, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear: req=%b ready=%b err=%b d=%h i=%h addr=%h expected all 0",
               mem_req, d_ready, mem_err, d_rdata, i_rdata, mem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    tick();
    vectors++;
    if ({mem_req, d_ready, i_ready} !== 3'b0 || d_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_late_ack: req=%b dr=%b ir=%b d=%h expected 0 0 0 0",
               mem_req, d_ready, i_ready, d_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_ack_at_limit();
    test_timeout();
    test_held_request();
    test_reset_mid();
    vectors++;
    if (i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d fetch and %0d data completions outstanding expected 0 0",
               i_exp_q.size(), d_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
